axi4lite_master: RTL and testbench

AXI4-Lite initiator that turns single-beat read/write commands from a local command port into AXI4-Lite transactions and returns the read data and response code on a response port. It is the requester-side counterpart of the AXI4-Lite slave and its backing memory, and drives that slave in system and block-level benches. It handles one outstanding transaction at a time and registers every AXI output.

---
 rtl/axi4lite_if.sv | 57 +++++
 rtl/axi4lite_master.sv | 242 ++++++++++++++++++++++++
 tb/tb_axi4lite_master.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_if.sv
// AXI4-Lite bus bundle shared by the master and the slave it drives.
// Master modport drives AW/W/AR and BREADY/RREADY; slave modport is the mirror image.
interface axi4lite_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;

  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;

  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, awprot,
    input  awready,
    output wvalid, wdata, wstrb,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arprot,
    input  arready,
    input  rvalid, rdata, rresp,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    output awready,
    input  wvalid, wdata, wstrb,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arprot,
    output arready,
    output rvalid, rdata, rresp,
    input  rready
  );
endinterface

// File: rtl/axi4lite_master.sv
// Single-outstanding AXI4-Lite initiator: one local command in, one AXI transaction out,
// one response back. Every output is a register; no input reaches an output combinationally.
module axi4lite_master #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  // Handshakes: a transfer happens on the rising edge where valid and ready are both high;
  // a valid, once raised, holds its payload stable until that edge and never waits on ready.
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  input  logic [STRB_W-1:0] i_cmd_wstrb,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic              o_rsp_write,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic [1:0]        o_rsp_resp,
  output logic              o_busy,
  output logic [2:0]        o_dbg_state,
  axi4lite_if.master        m_axi
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_RESP = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t r_state, w_state_n;

  logic              r_cmd_ready, w_cmd_ready_n;
  logic              r_busy,      w_busy_n;
  logic              r_write,     w_write_n;
  logic [ADDR_W-1:0] r_addr,      w_addr_n;
  logic [DATA_W-1:0] r_wdata,     w_wdata_n;
  logic [STRB_W-1:0] r_wstrb,     w_wstrb_n;
  logic              r_awvalid,   w_awvalid_n;
  logic              r_wvalid,    w_wvalid_n;
  logic              r_aw_done,   w_aw_done_n;
  logic              r_w_done,    w_w_done_n;
  logic              r_bready,    w_bready_n;
  logic              r_arvalid,   w_arvalid_n;
  logic              r_rready,    w_rready_n;
  logic              r_rsp_valid, w_rsp_valid_n;
  logic              r_rsp_write, w_rsp_write_n;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_n;
  logic [1:0]        r_rsp_resp,  w_rsp_resp_n;
  logic              w_aw_fin;
  logic              w_w_fin;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_cmd_ready_n = r_cmd_ready;
    w_write_n     = r_write;
    w_addr_n      = r_addr;
    w_wdata_n     = r_wdata;
    w_wstrb_n     = r_wstrb;
    w_awvalid_n   = r_awvalid;
    w_wvalid_n    = r_wvalid;
    w_aw_done_n   = r_aw_done;
    w_w_done_n    = r_w_done;
    w_bready_n    = r_bready;
    w_arvalid_n   = r_arvalid;
    w_rready_n    = r_rready;
    w_rsp_valid_n = r_rsp_valid;
    w_rsp_write_n = r_rsp_write;
    w_rsp_rdata_n = r_rsp_rdata;
    w_rsp_resp_n  = r_rsp_resp;

    // AW and W complete independently, in either order or together.
    w_aw_fin = r_aw_done | (r_awvalid & m_axi.awready);
    w_w_fin  = r_w_done  | (r_wvalid  & m_axi.wready);

    case (r_state)
      S_IDLE: begin
        w_cmd_ready_n = 1'b1;
        if (r_cmd_ready && i_cmd_valid) begin
          w_cmd_ready_n = 1'b0;
          w_write_n     = i_cmd_write;
          w_addr_n      = i_cmd_addr;
          w_wdata_n     = i_cmd_wdata;
          w_wstrb_n     = i_cmd_wstrb;
          if (i_cmd_write) begin
            w_state_n   = S_WR_REQ;
            w_awvalid_n = 1'b1;
            w_wvalid_n  = 1'b1;
            w_aw_done_n = 1'b0;
            w_w_done_n  = 1'b0;
          end else begin
            w_state_n   = S_RD_REQ;
            w_arvalid_n = 1'b1;
          end
        end
      end

      S_WR_REQ: begin
        w_awvalid_n = r_awvalid & ~m_axi.awready;
        w_wvalid_n  = r_wvalid  & ~m_axi.wready;
        w_aw_done_n = w_aw_fin;
        w_w_done_n  = w_w_fin;
        if (w_aw_fin && w_w_fin) begin
          w_state_n   = S_WR_RESP;
          w_aw_done_n = 1'b0;
          w_w_done_n  = 1'b0;
          w_bready_n  = 1'b1;
        end
      end

      S_WR_RESP: begin
        if (r_bready && m_axi.bvalid) begin
          w_state_n     = S_RESP;
          w_bready_n    = 1'b0;
          w_rsp_valid_n = 1'b1;
          w_rsp_write_n = r_write;
          w_rsp_rdata_n = '0;
          w_rsp_resp_n  = m_axi.bresp;
        end
      end

      S_RD_REQ: begin
        if (r_arvalid && m_axi.arready) begin
          w_state_n   = S_RD_RESP;
          w_arvalid_n = 1'b0;
          w_rready_n  = 1'b1;
        end
      end

      S_RD_RESP: begin
        if (r_rready && m_axi.rvalid) begin
          w_state_n     = S_RESP;
          w_rready_n    = 1'b0;
          w_rsp_valid_n = 1'b1;
          w_rsp_write_n = r_write;
          w_rsp_rdata_n = m_axi.rdata;
          w_rsp_resp_n  = m_axi.rresp;
        end
      end

      S_RESP: begin
        if (i_rsp_ready) begin
          w_state_n     = S_IDLE;
          w_rsp_valid_n = 1'b0;
          w_cmd_ready_n = 1'b1;
        end
      end

      default: begin
        w_state_n     = S_IDLE;
        w_cmd_ready_n = 1'b0;
        w_awvalid_n   = 1'b0;
        w_wvalid_n    = 1'b0;
        w_aw_done_n   = 1'b0;
        w_w_done_n    = 1'b0;
        w_bready_n    = 1'b0;
        w_arvalid_n   = 1'b0;
        w_rready_n    = 1'b0;
        w_rsp_valid_n = 1'b0;
      end
    endcase

    w_busy_n = (w_state_n != S_IDLE);
  end

  // cmd_ready stays low through reset and rises at the first edge that samples reset low.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
    end else begin
      r_cmd_ready <= w_cmd_ready_n;
      r_busy      <= w_busy_n;
      r_write     <= w_write_n;
      r_addr      <= w_addr_n;
      r_wdata     <= w_wdata_n;
      r_wstrb     <= w_wstrb_n;
      r_awvalid   <= w_awvalid_n;
      r_wvalid    <= w_wvalid_n;
      r_aw_done   <= w_aw_done_n;
      r_w_done    <= w_w_done_n;
      r_bready    <= w_bready_n;
      r_arvalid   <= w_arvalid_n;
      r_rready    <= w_rready_n;
      r_rsp_valid <= w_rsp_valid_n;
      r_rsp_write <= w_rsp_write_n;
      r_rsp_rdata <= w_rsp_rdata_n;
      r_rsp_resp  <= w_rsp_resp_n;
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_busy      = r_busy;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_write = r_rsp_write;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_resp  = r_rsp_resp;
  assign o_dbg_state = r_state;

  // One address register serves both AW and AR; only one of them is ever valid.
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.awaddr  = r_addr;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = r_wstrb;
  assign m_axi.bready  = r_bready;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.araddr  = r_addr;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.rready  = r_rready;

endmodule

// File: tb/tb_axi4lite_master.sv
// Directed bench for axi4lite_master: a delay-programmable AXI4-Lite slave with a word memory,
// command/response driver task, hand-computed expectations and an expected read-data queue.
module tb_axi4lite_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr  = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy;
  logic [2:0]  dbg_state;

  axi4lite_if #(.ADDR_W(8), .DATA_W(32)) axi ();

  axi4lite_master dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_write (cmd_write),
    .i_cmd_addr  (cmd_addr),
    .i_cmd_wdata (cmd_wdata),
    .i_cmd_wstrb (cmd_wstrb),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_write (rsp_write),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_resp  (rsp_resp),
    .o_busy      (busy),
    .o_dbg_state (dbg_state),
    .m_axi       (axi)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model (drives on negedge) ----------------
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_gap = 1, r_gap = 1;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] mem [64];

  initial begin
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        aw_got, w_got, wr_pend, rd_pend, b_hs_next, r_hs_next;
    logic [7:0]  aw_addr_l, ar_addr_l;
    logic [31:0] w_data_l;
    logic [3:0]  w_strb_l;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = '0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    aw_got = 0; w_got = 0; wr_pend = 0; rd_pend = 0; b_hs_next = 0; r_hs_next = 0;
    aw_addr_l = '0; ar_addr_l = '0; w_data_l = '0; w_strb_l = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
        axi.arready = 1'b0; axi.rvalid = 1'b0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        aw_got = 0; w_got = 0; wr_pend = 0; rd_pend = 0; b_hs_next = 0; r_hs_next = 0;
      end else begin
        // write response
        if (axi.bvalid && b_hs_next) begin axi.bvalid = 1'b0; b_hs_next = 0; end
        if (wr_pend) begin
          if (b_cnt == b_gap - 1) begin
            for (int i = 0; i < 4; i++)
              if (w_strb_l[i]) mem[aw_addr_l[7:2]][8*i +: 8] = w_data_l[8*i +: 8];
            axi.bvalid = 1'b1; axi.bresp = cfg_bresp; wr_pend = 0;
          end else b_cnt++;
        end
        if (axi.bvalid) b_hs_next = axi.bready;
        // write address / data
        if (axi.awvalid && !axi.awready) begin
          if (aw_cnt == aw_delay) begin axi.awready = 1'b1; aw_got = 1; aw_addr_l = axi.awaddr; end
          else aw_cnt++;
        end else begin axi.awready = 1'b0; aw_cnt = 0; end
        if (axi.wvalid && !axi.wready) begin
          if (w_cnt == w_delay) begin
            axi.wready = 1'b1; w_got = 1; w_data_l = axi.wdata; w_strb_l = axi.wstrb;
          end else w_cnt++;
        end else begin axi.wready = 1'b0; w_cnt = 0; end
        if (aw_got && w_got) begin wr_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0; end
        // read data
        if (axi.rvalid && r_hs_next) begin axi.rvalid = 1'b0; r_hs_next = 0; end
        if (rd_pend) begin
          if (r_cnt == r_gap - 1) begin
            axi.rvalid = 1'b1; axi.rdata = mem[ar_addr_l[7:2]]; axi.rresp = cfg_rresp; rd_pend = 0;
          end else r_cnt++;
        end
        if (axi.rvalid) r_hs_next = axi.rready;
        // read address
        if (axi.arvalid && !axi.arready) begin
          if (ar_cnt == ar_delay) begin axi.arready = 1'b1; rd_pend = 1; r_cnt = 0; ar_addr_l = axi.araddr; end
          else ar_cnt++;
        end else begin axi.arready = 1'b0; ar_cnt = 0; end
      end
    end
  end

  // ---------------- driver: one command, observed cycle by cycle ----------------
  int          o_aw_first, o_aw_last, o_w_last, o_b_first, o_ar_first, o_ar_last, o_r_first;
  int          o_rsp_cyc, o_done_cyc, o_bad_addr, o_bad_hold, o_bad_busy, o_rdy_bad, o_accept_wait;
  logic        o_rsp_write, o_idle_rdy, o_idle_busy;
  logic [1:0]  o_rsp_resp;

  task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int hold, input bit noise);
    int cyc, held;
    logic done;
    logic [31:0] rd_l;
    o_aw_first = 0; o_aw_last = 0; o_w_last = 0; o_b_first = 0; o_ar_first = 0; o_ar_last = 0;
    o_r_first = 0; o_rsp_cyc = 0; o_done_cyc = 0; o_bad_addr = 0; o_bad_hold = 0;
    o_bad_busy = 0; o_rdy_bad = 0; o_accept_wait = 0; o_rsp_write = 0; o_rsp_resp = 0;
    rd_l = '0; done = 1'b0; held = 0;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    while (!cmd_ready && o_accept_wait < 20) begin @(negedge clk); o_accept_wait++; end
    check("cmd_accepted", 32'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      if (axi.awvalid) begin
        if (o_aw_first == 0) o_aw_first = cyc;
        o_aw_last = cyc;
        if (axi.awaddr !== addr) o_bad_addr++;
      end
      if (axi.wvalid) begin
        o_w_last = cyc;
        if (axi.wdata !== data || axi.wstrb !== strb) o_bad_addr++;
      end
      if (axi.bready && o_b_first == 0) o_b_first = cyc;
      if (axi.arvalid) begin
        if (o_ar_first == 0) o_ar_first = cyc;
        o_ar_last = cyc;
        if (axi.araddr !== addr) o_bad_addr++;
      end
      if (axi.rready && o_r_first == 0) o_r_first = cyc;
      if (!busy) o_bad_busy++;
      if (cmd_ready) o_rdy_bad++;
      if (noise) begin
        cmd_valid = (cyc >= 2 && cyc <= 6); cmd_write = 1'b1;
        cmd_addr = 8'hFC; cmd_wdata = 32'hBAD0BAD0; cmd_wstrb = 4'hF;
      end
      if (rsp_valid) begin
        if (o_rsp_cyc == 0) begin
          o_rsp_cyc = cyc; o_rsp_write = rsp_write; o_rsp_resp = rsp_resp; rd_l = rsp_rdata;
        end else if (rsp_rdata !== rd_l || rsp_resp !== o_rsp_resp || rsp_write !== o_rsp_write) begin
          o_bad_hold++;
        end
        if (held < hold) begin rsp_ready = 1'b0; held++; end
        else begin rsp_ready = 1'b1; o_done_cyc = cyc; done = 1'b1; end
      end
      @(negedge clk);
      cyc++;
    end
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    o_idle_rdy  = cmd_ready;
    o_idle_busy = busy;
    check("rsp_seen", 32'(done), 1);
    if (exp_q.size() != 0) check("rsp_rdata", rd_l, exp_q.pop_front());
  endtask

  task automatic check_clean(input string tag);
    check({tag, "_payload_stable"}, o_bad_addr, 0);
    check({tag, "_busy_held"}, o_bad_busy, 0);
    check({tag, "_cmd_ready_low"}, o_rdy_bad, 0);
    check({tag, "_idle_cmd_ready"}, 32'(o_idle_rdy), 1);
    check({tag, "_idle_busy"}, 32'(o_idle_busy), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_valids", {27'd0, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_awaddr", 32'(axi.awaddr), 0);
    check("rst_wdata", axi.wdata, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_resp", 32'(rsp_resp), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 1);

    // zero-wait write
    exp_q.push_back(32'h0);
    run_txn(1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    check("wr0_aw_first", o_aw_first, 1);
    check("wr0_aw_last", o_aw_last, 1);
    check("wr0_w_last", o_w_last, 1);
    check("wr0_bready", o_b_first, 2);
    check("wr0_rsp_cyc", o_rsp_cyc, 3);
    check("wr0_rsp_write", 32'(o_rsp_write), 1);
    check("wr0_rsp_resp", 32'(o_rsp_resp), 0);
    check("wr0_mem1", mem[1], 32'hDEADBEEF);
    check_clean("wr0");

    // zero-wait read back
    exp_q.push_back(32'hDEADBEEF);
    run_txn(1'b0, 8'h04, 32'h0, 4'h0, 0, 1'b0);
    check("rd0_ar_first", o_ar_first, 1);
    check("rd0_rready", o_r_first, 2);
    check("rd0_rsp_cyc", o_rsp_cyc, 3);
    check("rd0_rsp_write", 32'(o_rsp_write), 0);
    check("rd0_rsp_resp", 32'(o_rsp_resp), 0);
    check("rd0_no_aw", o_aw_first, 0);
    check_clean("rd0");

    // W three cycles ahead of AW
    aw_delay = 3; w_delay = 0;
    exp_q.push_back(32'h0);
    run_txn(1'b1, 8'h08, 32'h11223344, 4'hF, 0, 1'b0);
    check("wr1_w_last", o_w_last, 1);
    check("wr1_aw_last", o_aw_last, 4);
    check("wr1_bready", o_b_first, 5);
    check("wr1_rsp_cyc", o_rsp_cyc, 6);
    check("wr1_mem2", mem[2], 32'h11223344);
    check_clean("wr1");

    // AW three cycles ahead of W, partial strobe
    aw_delay = 0; w_delay = 3;
    exp_q.push_back(32'h0);
    run_txn(1'b1, 8'h0C, 32'hCAFEF00D, 4'h3, 0, 1'b0);
    check("wr2_aw_last", o_aw_last, 1);
    check("wr2_w_last", o_w_last, 4);
    check("wr2_bready", o_b_first, 5);
    check("wr2_rsp_cyc", o_rsp_cyc, 6);
    check("wr2_mem3", mem[3], 32'h0000F00D);
    check_clean("wr2");

    // both handshakes in the same late cycle, DECERR passed through
    aw_delay = 2; w_delay = 2; cfg_bresp = 2'b11;
    exp_q.push_back(32'h0);
    run_txn(1'b1, 8'h10, 32'hA5A5A5A5, 4'hF, 0, 1'b0);
    check("wr3_aw_last", o_aw_last, 3);
    check("wr3_w_last", o_w_last, 3);
    check("wr3_bready", o_b_first, 4);
    check("wr3_rsp_cyc", o_rsp_cyc, 5);
    check("wr3_rsp_resp", 32'(o_rsp_resp), 3);
    check_clean("wr3");
    aw_delay = 0; w_delay = 0; cfg_bresp = 2'b00;

    // slow read with SLVERR and cmd_valid noise while busy
    ar_delay = 5; r_gap = 2; cfg_rresp = 2'b10;
    exp_q.push_back(32'h11223344);
    run_txn(1'b0, 8'h08, 32'h0, 4'h0, 0, 1'b1);
    check("rd1_ar_last", o_ar_last, 6);
    check("rd1_rready", o_r_first, 7);
    check("rd1_rsp_cyc", o_rsp_cyc, 9);
    check("rd1_rsp_resp", 32'(o_rsp_resp), 2);
    check("rd1_mem63_untouched", mem[63], 0);
    check_clean("rd1");
    ar_delay = 0; r_gap = 1; cfg_rresp = 2'b00;

    // strobed word read back
    exp_q.push_back(32'h0000F00D);
    run_txn(1'b0, 8'h0C, 32'h0, 4'h0, 0, 1'b0);
    check("rd2_rsp_cyc", o_rsp_cyc, 3);

    // response held off for 4 cycles, then an immediate back-to-back write
    exp_q.push_back(32'hA5A5A5A5);
    run_txn(1'b0, 8'h10, 32'h0, 4'h0, 4, 1'b0);
    check("rd3_rsp_cyc", o_rsp_cyc, 3);
    check("rd3_done_cyc", o_done_cyc, 7);
    check("rd3_rsp_stable", o_bad_hold, 0);
    check_clean("rd3");
    exp_q.push_back(32'h0);
    run_txn(1'b1, 8'h14, 32'h01020304, 4'hF, 0, 1'b0);
    check("wr4_accept_wait", o_accept_wait, 0);
    check("wr4_aw_first", o_aw_first, 1);
    check("wr4_rsp_cyc", o_rsp_cyc, 3);
    check("wr4_mem5", mem[5], 32'h01020304);

    // reset while AW is still pending
    aw_delay = 10;
    cmd_write = 1'b1; cmd_addr = 8'h18; cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
    check("rstx_cmd_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rstx_awvalid_pending", 32'(axi.awvalid), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstx_valids", {27'd0, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
    check("rstx_rsp_valid", 32'(rsp_valid), 0);
    check("rstx_busy", 32'(busy), 0);
    check("rstx_cmd_ready", 32'(cmd_ready), 0);
    check("rstx_state", 32'(dbg_state), 0);
    @(negedge clk);
    rst = 1'b0;
    aw_delay = 0;
    @(negedge clk);
    check("rstx_cmd_ready_after", 32'(cmd_ready), 1);
    check("rstx_mem6_unwritten", mem[6], 0);

    // operation resumes after reset
    exp_q.push_back(32'hDEADBEEF);
    run_txn(1'b0, 8'h04, 32'h0, 4'h0, 0, 1'b0);
    check("rd4_rsp_cyc", o_rsp_cyc, 3);
    check_clean("rd4");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    n_miss++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
